wb_write_arbiter: RTL and testbench
===================================

Name: wb_write_arbiter

Overview:
- Writeback-side producer for the register file's single write port (`reg_wen`, `reg_waddr_i`, `reg_wdata_i`).
- Merges two result sources into one registered write per cycle:
  - single-cycle ALU results from EX;
  - long-latency results (load/divide) through a small FIFO.
- Keeps a 32-bit scoreboard of registers with an outstanding long-latency write. ID uses it for hazard stalls.

Parameters:
- FIFO_DEPTH, 4, entries in the long-latency result FIFO (power of 2, ≥2).
- STARVE_MAX, 3, consecutive cycles the FIFO head may lose to the ALU before it is forced through (guard build only).

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-low
- alu_valid_i  in  1  ALU result valid this cycle
- alu_rd_i  in  5  ALU destination register
- alu_data_i  in  32  ALU result
- alu_stall_o  out  1  ALU result not taken this cycle; EX must hold it
- ll_valid_i  in  1  long-latency result valid
- ll_ready_o  out  1  FIFO can accept
- ll_rd_i  in  5  long-latency destination
- ll_data_i  in  32  long-latency result
- issue_valid_i  in  1  long-latency op issued this cycle
- issue_rd_i  in  5  its destination
- busy_o  out  32  scoreboard; bit n = x_n has a pending long-latency write
- reg_wen_o  out  1  register-file write enable
- reg_waddr_o  out  5  write address
- reg_wdata_o  out  32  write data
- fifo_count_o  out  $clog2(FIFO_DEPTH)+1  FIFO occupancy

Behaviour:
- Reset (rst=0, asynchronous), all outputs and state cleared:
  - reg_wen_o=0, reg_waddr_o=0, reg_wdata_o=0, busy_o=0, fifo_count_o=0;
  - starvation counter=0, FIFO pointers=0.
  - ll_ready_o=1 and alu_stall_o=0 immediately.
  - Reset mid-operation discards all queued results.
- Write-request qualification:
  - ALU request = alu_valid_i && alu_rd_i!=0.
  - FIFO request = fifo_count_o!=0.
- Grant, evaluated per cycle:
  - force=1: FIFO head wins.
  - Else if an ALU request is present: ALU wins.
  - Else if the FIFO is non-empty: FIFO head wins.
  - Else: no write.
  - alu_stall_o = force && alu_valid_i (combinational).
- Write commit:
  - The granted source is registered into reg_wen_o/reg_waddr_o/reg_wdata_o at the next posedge, giving 1-cycle latency.
  - reg_wen_o=0 in any cycle with no grant.
- FIFO handshake:
  - ll_ready_o = fifo_count_o<FIFO_DEPTH.
  - Enqueue on ll_valid_i && ll_ready_o when ll_rd_i!=0.
  - An accepted result with ll_rd_i==0 is dropped (not enqueued).
  - Dequeue on FIFO grant.
  - Simultaneous enqueue and dequeue: count unchanged.
  - Full FIFO with simultaneous dequeue: ll_ready_o stays 0 that cycle.
  - Pointers wrap modulo FIFO_DEPTH.
- Scoreboard:
  - Set bit issue_rd_i on issue_valid_i when issue_rd_i!=0.
  - Clear bit rd when a FIFO grant for rd is registered.
  - Set and clear on the same rd in the same cycle: set wins.
  - busy_o[0] is always 0.
- WAW ordering is the issuer's responsibility: ID must not issue ALU writes to a busy register. The arbiter does no address comparison.
- Starvation counter (guard build):
  - Increments when the FIFO is non-empty and the ALU is granted.
  - Resets to 0 on FIFO grant or when the FIFO is empty.
  - force = counter==STARVE_MAX.

Optional Feature:
- Macro WB_STARVE_GUARD_EN.
- Defined: starvation counter and force path present, as specified above.
- Undefined:
  - strict ALU priority, no counter;
  - force=0, so alu_stall_o is constant 0;
  - the FIFO drains only in cycles with no ALU request.

Test Plan:
- Reset then ALU valid, rd=5, data=0x12345678 for 1 cycle → next cycle reg_wen_o=1, reg_waddr_o=5, reg_wdata_o=0x12345678; following cycle reg_wen_o=0.
- issue rd=7, then LL result rd=7, data=0xA5A5A5A5 with no ALU traffic → busy_o[7]=1 after issue; write of x7 one cycle after enqueue+grant; busy_o[7]=0 the cycle after the write registers.
- 4 LL enqueues with ALU continuously valid → ll_ready_o=0 after the 4th, count=4.
  - Guard build: 3 ALU writes, then alu_stall_o=1 for one cycle and FIFO head written.
  - No-guard build: FIFO never drains while ALU stays valid.
- LL result with rd=0, and ALU with rd=0 → no enqueue (count stays 0), reg_wen_o stays 0.
- issue_valid_i rd=9 in the same cycle the FIFO head for rd=9 is granted → busy_o[9]=1 after that edge.
- Assert rst mid-drain with count=3 → all outputs 0 asynchronously, ll_ready_o=1, queued entries never written after release.

Source files
------------

// File: rtl/wb_write_arbiter_if.sv
// Writeback arbiter bus bundle: ALU result, long-latency result, issue tag,
// scoreboard and register-file write port. slave = arbiter side, master = driver side.
interface wb_write_arbiter_if #(
  parameter int FIFO_DEPTH = 4
);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  logic          alu_valid_i;
  logic [4:0]    alu_rd_i;
  logic [31:0]   alu_data_i;
  logic          alu_stall_o;
  logic          ll_valid_i;
  logic          ll_ready_o;
  logic [4:0]    ll_rd_i;
  logic [31:0]   ll_data_i;
  logic          issue_valid_i;
  logic [4:0]    issue_rd_i;
  logic [31:0]   busy_o;
  logic          reg_wen_o;
  logic [4:0]    reg_waddr_o;
  logic [31:0]   reg_wdata_o;
  logic [CW-1:0] fifo_count_o;

  modport slave (
    input  alu_valid_i, alu_rd_i, alu_data_i,
    input  ll_valid_i, ll_rd_i, ll_data_i,
    input  issue_valid_i, issue_rd_i,
    output alu_stall_o, ll_ready_o, busy_o,
    output reg_wen_o, reg_waddr_o, reg_wdata_o, fifo_count_o
  );

  modport master (
    output alu_valid_i, alu_rd_i, alu_data_i,
    output ll_valid_i, ll_rd_i, ll_data_i,
    output issue_valid_i, issue_rd_i,
    input  alu_stall_o, ll_ready_o, busy_o,
    input  reg_wen_o, reg_waddr_o, reg_wdata_o, fifo_count_o
  );
endinterface

// File: rtl/wb_write_arbiter.sv
// Register-file write-port arbiter: ALU results vs. a FIFO of long-latency results,
// plus a pending-write scoreboard. Define WB_STARVE_GUARD_EN to add the FIFO starvation guard.
module wb_write_arbiter #(
  parameter int FIFO_DEPTH = 4
`ifdef WB_STARVE_GUARD_EN
  , parameter int STARVE_MAX = 3
`endif
) (
  input  logic              clk,
  input  logic              rst,
  wb_write_arbiter_if.slave bus
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;

  logic [4:0]    r_fifo_rd   [FIFO_DEPTH];
  logic [31:0]   r_fifo_data [FIFO_DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [CW-1:0] r_count;
  logic          r_wen;
  logic [4:0]    r_waddr;
  logic [31:0]   r_wdata;
  logic [31:0]   r_busy;

  logic          w_alu_req;
  logic          w_fifo_req;
  logic          w_force;
  logic          w_grant_alu;
  logic          w_grant_fifo;
  logic          w_ready;
  logic          w_enq;
  logic [4:0]    w_head_rd;
  logic [31:0]   w_head_data;
  logic [31:0]   w_busy_set;
  logic [31:0]   w_busy_clr;

  assign w_alu_req    = bus.alu_valid_i && (bus.alu_rd_i != 5'd0);
  assign w_fifo_req   = (r_count != '0);
  assign w_ready      = (r_count < CW'(FIFO_DEPTH));
  assign w_enq        = bus.ll_valid_i && w_ready && (bus.ll_rd_i != 5'd0);
  assign w_grant_fifo = w_fifo_req && (w_force || !w_alu_req);
  assign w_grant_alu  = !w_force && w_alu_req;
  assign w_head_rd    = r_fifo_rd[r_rd_ptr];
  assign w_head_data  = r_fifo_data[r_rd_ptr];

`ifdef WB_STARVE_GUARD_EN
  localparam int SW = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);
  logic [SW-1:0] r_starve;

  // Counts consecutive cycles the FIFO head lost to the ALU.
  assign w_force = (r_starve == SW'(STARVE_MAX));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_starve <= '0;
    end else if (!w_fifo_req || w_grant_fifo) begin
      r_starve <= '0;
    end else if (w_grant_alu) begin
      r_starve <= r_starve + 1'b1;
    end
  end
`else
  assign w_force = 1'b0;
`endif

  // Result storage carries no reset; occupancy and pointers decide validity.
  always_ff @(posedge clk) begin
    if (w_enq) begin
      r_fifo_rd[r_wr_ptr]   <= bus.ll_rd_i;
      r_fifo_data[r_wr_ptr] <= bus.ll_data_i;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_enq) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_grant_fifo) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      case ({w_enq, w_grant_fifo})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wen   <= 1'b0;
      r_waddr <= 5'd0;
      r_wdata <= 32'd0;
    end else if (w_grant_fifo) begin
      r_wen   <= 1'b1;
      r_waddr <= w_head_rd;
      r_wdata <= w_head_data;
    end else if (w_grant_alu) begin
      r_wen   <= 1'b1;
      r_waddr <= bus.alu_rd_i;
      r_wdata <= bus.alu_data_i;
    end else begin
      r_wen   <= 1'b0;
    end
  end

  // A new issue to the register being retired keeps it busy (set applied after clear).
  assign w_busy_set = (bus.issue_valid_i && (bus.issue_rd_i != 5'd0)) ? (32'd1 << bus.issue_rd_i) : 32'd0;
  assign w_busy_clr = w_grant_fifo ? (32'd1 << w_head_rd) : 32'd0;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_busy <= 32'd0;
    end else begin
      r_busy <= ((r_busy & ~w_busy_clr) | w_busy_set) & ~32'd1;
    end
  end

  assign bus.alu_stall_o  = w_force && bus.alu_valid_i;
  assign bus.ll_ready_o   = w_ready;
  assign bus.busy_o       = r_busy;
  assign bus.reg_wen_o    = r_wen;
  assign bus.reg_waddr_o  = r_waddr;
  assign bus.reg_wdata_o  = r_wdata;
  assign bus.fifo_count_o = r_count;
endmodule

// File: tb/tb_wb_write_arbiter.sv
// Self-checking bench for wb_write_arbiter: directed scenarios plus random traffic
// checked every cycle against a queue-based reference model.
module tb_wb_write_arbiter;
  localparam int DEPTH      = 4;
  localparam int STARVE_MAX = 3;
`ifdef WB_STARVE_GUARD_EN
  localparam bit GUARD = 1'b1;
`else
  localparam bit GUARD = 1'b0;
`endif

  typedef struct {
    logic [4:0]  rd;
    logic [31:0] d;
  } ent_t;

  logic clk;
  logic rst;
  int   n_tests;
  int   n_fail;

  ent_t        m_q[$];
  logic [31:0] m_busy;
  int          m_starve;
  logic        m_wen;
  logic [4:0]  m_addr;
  logic [31:0] m_data;

  wb_write_arbiter_if #(.FIFO_DEPTH(DEPTH)) bus ();

  wb_write_arbiter #(.FIFO_DEPTH(DEPTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_q.delete();
    m_busy   = 32'd0;
    m_starve = 0;
    m_wen    = 1'b0;
    m_addr   = 5'd0;
    m_data   = 32'd0;
  endtask

  // One clock cycle: drive, check combinational outputs, advance model, check registered outputs.
  task automatic step(input logic av, input logic [4:0] ard, input logic [31:0] ad,
                      input logic lv, input logic [4:0] lrd, input logic [31:0] ld,
                      input logic iv, input logic [4:0] ird);
    logic frc, areq, gf, ga, rdy;
    ent_t h;
    bus.alu_valid_i   = av;
    bus.alu_rd_i      = ard;
    bus.alu_data_i    = ad;
    bus.ll_valid_i    = lv;
    bus.ll_rd_i       = lrd;
    bus.ll_data_i     = ld;
    bus.issue_valid_i = iv;
    bus.issue_rd_i    = ird;
    #2;
    frc  = GUARD && (m_starve == STARVE_MAX);
    areq = av && (ard != 5'd0);
    gf   = (m_q.size() != 0) && (frc || !areq);
    ga   = !frc && areq;
    rdy  = (m_q.size() < DEPTH);
    chk("alu_stall", 32'(bus.alu_stall_o), 32'(frc && av));
    chk("ll_ready", 32'(bus.ll_ready_o), 32'(rdy));
    if (GUARD) begin
      if (m_q.size() == 0 || gf) m_starve = 0;
      else if (ga) m_starve++;
    end
    if (gf) begin
      h = m_q.pop_front();
      m_wen = 1'b1;
      m_addr = h.rd;
      m_data = h.d;
      m_busy[h.rd] = 1'b0;
    end else if (ga) begin
      m_wen = 1'b1;
      m_addr = ard;
      m_data = ad;
    end else begin
      m_wen = 1'b0;
    end
    if (lv && rdy && lrd != 5'd0) m_q.push_back('{rd: lrd, d: ld});
    if (iv && ird != 5'd0) m_busy[ird] = 1'b1;
    @(posedge clk);
    #1;
    chk("reg_wen", 32'(bus.reg_wen_o), 32'(m_wen));
    if (m_wen) begin
      chk("reg_waddr", 32'(bus.reg_waddr_o), 32'(m_addr));
      chk("reg_wdata", bus.reg_wdata_o, m_data);
    end
    chk("busy", bus.busy_o, m_busy);
    chk("fifo_count", 32'(bus.fifo_count_o), 32'(m_q.size()));
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0);
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, "_wen"}, 32'(bus.reg_wen_o), 32'd0);
    chk({tag, "_waddr"}, 32'(bus.reg_waddr_o), 32'd0);
    chk({tag, "_wdata"}, bus.reg_wdata_o, 32'd0);
    chk({tag, "_busy"}, bus.busy_o, 32'd0);
    chk({tag, "_count"}, 32'(bus.fifo_count_o), 32'd0);
    chk({tag, "_ready"}, 32'(bus.ll_ready_o), 32'd1);
    chk({tag, "_stall"}, 32'(bus.alu_stall_o), 32'd0);
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    model_reset();
    bus.alu_valid_i   = 1'b0;
    bus.alu_rd_i      = 5'd0;
    bus.alu_data_i    = 32'd0;
    bus.ll_valid_i    = 1'b0;
    bus.ll_rd_i       = 5'd0;
    bus.ll_data_i     = 32'd0;
    bus.issue_valid_i = 1'b0;
    bus.issue_rd_i    = 5'd0;
    rst = 1'b1;
    #1 rst = 1'b0;
    #1;
    chk_reset_state("rst0");
    @(posedge clk);
    @(posedge clk);
    #1 rst = 1'b1;

    // Single ALU write, one-cycle latency then idle.
    step(1'b1, 5'd5, 32'h12345678, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0);
    chk("t1_wen", 32'(bus.reg_wen_o), 32'd1);
    chk("t1_waddr", 32'(bus.reg_waddr_o), 32'd5);
    chk("t1_wdata", bus.reg_wdata_o, 32'h12345678);
    idle(1);
    chk("t1_wen_off", 32'(bus.reg_wen_o), 32'd0);

    // Issue x7, return its long-latency result.
    step(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd7);
    chk("t2_busy7_set", 32'(bus.busy_o[7]), 32'd1);
    step(1'b0, 5'd0, 32'd0, 1'b1, 5'd7, 32'hA5A5A5A5, 1'b0, 5'd0);
    idle(1);
    chk("t2_wen", 32'(bus.reg_wen_o), 32'd1);
    chk("t2_waddr", 32'(bus.reg_waddr_o), 32'd7);
    chk("t2_wdata", bus.reg_wdata_o, 32'hA5A5A5A5);
    chk("t2_busy7_clr", 32'(bus.busy_o[7]), 32'd0);
    idle(1);

    // Fill the FIFO while the ALU stays valid.
    for (int i = 0; i < 4; i++)
      step(1'b1, 5'(10 + i), 32'(i * 3 + 1), 1'b1, 5'(20 + i), 32'hCAFE0000 + 32'(i), 1'b1, 5'(20 + i));
    chk("t3_count4", 32'(bus.fifo_count_o), 32'd4);
    chk("t3_ready0", 32'(bus.ll_ready_o), 32'd0);
    for (int i = 0; i < 8; i++)
      step(1'b1, 5'(1 + i), $urandom, 1'b1, 5'd3, $urandom, 1'b0, 5'd0);
    idle(8);

    // rd=0 results are neither enqueued nor written.
    step(1'b1, 5'd0, 32'hDEADBEEF, 1'b1, 5'd0, 32'hBEEFDEAD, 1'b0, 5'd0);
    chk("t4_count0", 32'(bus.fifo_count_o), 32'd0);
    chk("t4_wen0", 32'(bus.reg_wen_o), 32'd0);
    idle(1);

    // Re-issue x9 in the same cycle its pending result retires.
    step(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd9);
    step(1'b0, 5'd0, 32'd0, 1'b1, 5'd9, 32'h00000999, 1'b0, 5'd0);
    step(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd9);
    chk("t5_wen", 32'(bus.reg_wen_o), 32'd1);
    chk("t5_waddr", 32'(bus.reg_waddr_o), 32'd9);
    chk("t5_busy9", 32'(bus.busy_o[9]), 32'd1);
    idle(2);

    // Random mixed traffic.
    for (int i = 0; i < 1500; i++)
      step(1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)), $urandom,
           1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)), $urandom,
           1'($urandom_range(0, 3) == 0), 5'($urandom_range(0, 31)));
    idle(8);

    // Asynchronous reset while three results are queued.
    for (int i = 0; i < 3; i++)
      step(1'b1, 5'(4 + i), $urandom, 1'b1, 5'(12 + i), $urandom, 1'b0, 5'd0);
    chk("t6_count3", 32'(bus.fifo_count_o), 32'd3);
    bus.alu_valid_i = 1'b1;
    bus.alu_rd_i    = 5'd6;
    bus.ll_valid_i  = 1'b0;
    #2 rst = 1'b0;
    #1;
    chk_reset_state("rst_mid");
    model_reset();
    @(posedge clk);
    #1;
    chk_reset_state("rst_hold");
    rst = 1'b1;
    idle(6);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
